// File: rtl/rc5_key_sched_pkg.sv
// rc5_pkg: shared RC5-32 constants, default geometry, FSM states and the word rotate.
package rc5_pkg;
   localparam int          W         = 32;
   localparam logic [31:0] P32       = 32'hB7E15163;
   localparam logic [31:0] Q32       = 32'h9E3779B9;
   localparam int          ROUNDS    = 12;
   localparam int          KEY_WORDS = 4;
   localparam int          T         = 2*ROUNDS+2;
   localparam int          N_ITER    = 3*((T > KEY_WORDS) ? T : KEY_WORDS);

   typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

   // Doubling the word makes a zero amount fall out naturally with no shift by W.
   function automatic logic [31:0] rotl32(input logic [31:0] val, input logic [4:0] amt);
      logic [63:0] w_t;
      w_t = {val, val} << amt;
      return w_t[63:32];
   endfunction
endpackage

// File: rtl/rc5_key_sched_if.sv
// rc5_key_sched_if: key handshake and subkey bus; kcv present only with RC5_KS_KCV_EN.
interface rc5_key_sched_if #(parameter int NT = rc5_pkg::T, parameter int NK = rc5_pkg::KEY_WORDS);
   logic [32*NK-1:0] key_in;
   logic             key_vld;
   logic             key_rdy;
   logic             busy;
   logic [32*NT-1:0] skey_flat;
   logic             skey_vld;
`ifdef RC5_KS_KCV_EN
   logic [31:0]      kcv;
`endif

   modport master (
      output key_in, key_vld,
`ifdef RC5_KS_KCV_EN
      input  kcv,
`endif
      input  key_rdy, busy, skey_flat, skey_vld
   );

   modport slave (
      input  key_in, key_vld,
`ifdef RC5_KS_KCV_EN
      output kcv,
`endif
      output key_rdy, busy, skey_flat, skey_vld
   );
endinterface

// File: rtl/rc5_key_sched_step.sv
// rc5_ks_step: one combinational RC5 key-mixing iteration (S_i, L_j, A, B) -> (A', B').
module rc5_ks_step
   import rc5_pkg::*;
(
   input  logic [31:0] i_s,
   input  logic [31:0] i_l,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_a,
   output logic [31:0] o_b
);
   logic [31:0] w_ab;

   always_comb begin
      o_a  = rotl32(i_s + i_a + i_b, 5'd3);
      w_ab = o_a + i_b;
      o_b  = rotl32(i_l + w_ab, w_ab[4:0]);
   end
endmodule

// File: rtl/rc5_key_sched.sv
// rc5_key_sched: sequential RC5-32 key expansion, one mixing iteration per clock.
// Optional RC5_KS_KCV_EN adds kcv = XOR of all subkeys, registered with skey_vld.
module rc5_key_sched
   import rc5_pkg::*;
#(
   parameter int ROUNDS    = rc5_pkg::ROUNDS,
   parameter int KEY_WORDS = rc5_pkg::KEY_WORDS
) (
   input  logic             clk,
   input  logic             clr,
   rc5_key_sched_if.slave   bus
);
   localparam int NT = 2*ROUNDS+2;
   localparam int NI = 3*((NT > KEY_WORDS) ? NT : KEY_WORDS);
   localparam int IW = $clog2(NT);
   localparam int JW = $clog2((KEY_WORDS > 1) ? KEY_WORDS : 2);
   localparam int CW = $clog2(NI);

   state_t          r_state, w_next;
   logic [31:0]     r_s [NT];
   logic [31:0]     r_l [KEY_WORDS];
   logic [31:0]     r_a, r_b, w_a, w_b;
   logic [IW-1:0]   r_i;
   logic [JW-1:0]   r_j;
   logic [CW-1:0]   r_cnt;
   logic            r_vld, r_live, w_hs, w_last;

   rc5_ks_step u_step (
      .i_s (r_s[r_i]),
      .i_l (r_l[r_j]),
      .i_a (r_a),
      .i_b (r_b),
      .o_a (w_a),
      .o_b (w_b)
   );

   // r_live keeps key_rdy low until the first edge after reset release.
   assign bus.key_rdy  = r_live && (r_state != MIX);
   assign bus.busy     = (r_state == MIX);
   assign bus.skey_vld = r_vld;
   assign w_hs         = bus.key_vld && bus.key_rdy;
   assign w_last       = (r_state == MIX) && (r_cnt == CW'(NI-1));

   for (genvar g = 0; g < NT; g++) begin : g_flat
      assign bus.skey_flat[32*g +: 32] = r_s[g];
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_hs)        w_next = MIX;
      else if (w_last) w_next = DONE;
   end

`ifdef RC5_KS_KCV_EN
   logic [31:0] r_kcv, w_x;

   // The final iteration's write to S[i] lands on the same edge, so fold it in here.
   always_comb begin
      w_x = w_a ^ r_s[r_i];
      for (int n = 0; n < NT; n++) w_x = w_x ^ r_s[n];
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)        r_kcv <= '0;
      else if (w_hs)   r_kcv <= '0;
      else if (w_last) r_kcv <= w_x;
   end

   assign bus.kcv = r_kcv;
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int n = 0; n < NT; n++) r_s[n] <= '0;
         for (int k = 0; k < KEY_WORDS; k++) r_l[k] <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_i    <= '0;
         r_j    <= '0;
         r_cnt  <= '0;
         r_vld  <= 1'b0;
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (w_hs) begin
            for (int n = 0; n < NT; n++) r_s[n] <= P32 + 32'(n) * Q32;
            for (int k = 0; k < KEY_WORDS; k++) r_l[k] <= bus.key_in[32*k +: 32];
            r_a   <= '0;
            r_b   <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_cnt <= '0;
            r_vld <= 1'b0;
         end else if (r_state == MIX) begin
            r_s[r_i] <= w_a;
            r_l[r_j] <= w_b;
            r_a      <= w_a;
            r_b      <= w_b;
            r_i      <= (r_i == IW'(NT-1)) ? '0 : r_i + 1'b1;
            r_j      <= (r_j == JW'(KEY_WORDS-1)) ? '0 : r_j + 1'b1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) r_vld <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rc5_key_sched.sv
// tb_rc5_key_sched: randomized scoreboard bench against a plain-arithmetic RC5 key expansion model.
// Exercises kcv too when RC5_KS_KCV_EN is defined.
module tb_rc5_key_sched;
   import rc5_pkg::*;
   localparam int NT = T;
   localparam int NI = N_ITER;
   typedef logic [32*NT-1:0] flat_t;
   typedef struct {
      flat_t       flat;
      logic [31:0] kcv;
      int          cyc;
   } exp_t;

   exp_t q[$];
   logic clk = 1'b0;
   logic clr = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   rc5_key_sched_if bus();
   rc5_key_sched dut (.clk(clk), .clr(clr), .bus(bus.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rl(input logic [31:0] x, input int r);
      int m;
      m = r % 32;
      return (x << m) | (x >> (32 - m));
   endfunction

   function automatic flat_t model(input logic [127:0] key);
      logic [31:0] s [NT];
      logic [31:0] l [4];
      logic [31:0] a, b;
      flat_t f;
      a = 0;
      b = 0;
      for (int n = 0; n < NT; n++) s[n] = P32 + n * Q32;
      for (int k = 0; k < 4; k++) l[k] = key[32*k +: 32];
      for (int k = 0; k < NI; k++) begin
         a = rl(s[k % NT] + a + b, 3);
         s[k % NT] = a;
         b = rl(l[k % 4] + a + b, int'((a + b) % 32));
         l[k % 4] = b;
      end
      for (int n = 0; n < NT; n++) f[32*n +: 32] = s[n];
      return f;
   endfunction

   function automatic logic [31:0] xor_of(input flat_t f);
      logic [31:0] x;
      x = 0;
      for (int n = 0; n < NT; n++) x ^= f[32*n +: 32];
      return x;
   endfunction

   function automatic logic [63:0] enc(input flat_t f);
      logic [31:0] a, b;
      a = f[31:0];
      b = f[63:32];
      for (int r = 1; r <= ROUNDS; r++) begin
         a = rl(a ^ b, int'(b % 32)) + f[32*(2*r) +: 32];
         b = rl(b ^ a, int'(a % 32)) + f[32*(2*r+1) +: 32];
      end
      return {a, b};
   endfunction

   task automatic chk(input string nm, input flat_t act, input flat_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [127:0] k, input bit push = 1, input bit hold = 0);
      int n = 0;
      exp_t e;
      @(negedge clk);
      bus.key_in  = k;
      bus.key_vld = 1'b1;
      while (!bus.key_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.key_rdy) begin
         chk("rdy_timeout", 0, 1);
         bus.key_vld = 1'b0;
         return;
      end
      if (push) begin
         e.flat = model(k);
         e.kcv  = xor_of(e.flat);
         e.cyc  = cyc + NI + 1;
         q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      chk("busy_after_hs", bus.busy, 1);
      chk("rdy_after_hs", bus.key_rdy, 0);
      chk("vld_after_hs", bus.skey_vld, 0);
`ifdef RC5_KS_KCV_EN
      chk("kcv_after_hs", bus.kcv, 0);
`endif
      if (hold) begin
         repeat (20) begin
            bus.key_in = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
         end
      end
      bus.key_vld = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!bus.skey_vld && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", bus.skey_vld, 1);
   endtask

   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.skey_vld && !prev) begin
            if (q.size() == 0) chk("unexpected_vld", 1, 0);
            else begin
               e = q.pop_front();
               chk("skey_flat", bus.skey_flat, e.flat);
               chk("latency", cyc, e.cyc);
`ifdef RC5_KS_KCV_EN
               chk("kcv", bus.kcv, e.kcv);
`endif
            end
         end
         prev = bus.skey_vld;
      end
   end

   initial begin
      logic [127:0] k;
      int n;
      bus.key_in  = '0;
      bus.key_vld = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_rdy", bus.key_rdy, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_vld", bus.skey_vld, 0);
      chk("reset_flat", bus.skey_flat, 0);
      clr = 1'b1;
      @(negedge clk);
      chk("rdy_after_release", bus.key_rdy, 1);
      send(128'h0);
      wait_done();
      chk("enc_vector1", enc(bus.skey_flat), 64'hEEDBA5216D8F4B15);
      repeat (5) @(negedge clk);
      chk("vld_sticky", bus.skey_vld, 1);
      send({$urandom, $urandom, $urandom, $urandom});
      wait_done();
      send({$urandom, $urandom, $urandom, $urandom}, 1, 1);
      wait_done();
      send({$urandom, $urandom, $urandom, $urandom}, 0);
      repeat (40) @(negedge clk);
      clr = 1'b0;
      #1;
      chk("abort_flat", bus.skey_flat, 0);
      chk("abort_vld", bus.skey_vld, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_rdy", bus.key_rdy, 0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      chk("rdy_after_abort", bus.key_rdy, 1);
      send({$urandom, $urandom, $urandom, $urandom});
      wait_done();
      for (int r = 0; r < 100; r++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         k = {$urandom, $urandom, $urandom, $urandom};
         send(k);
         wait_done();
      end
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
